// File: rtl/card_dealer.sv
// card_dealer: shoe of per-rank counts, LFSR-driven card picker and a deal FSM
// that presents each card one full cycle before its add strobe.
module card_dealer #(
    parameter int          NUM_DECKS    = 1,
    parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_shuffle,
    input  logic [15:0] i_seed,
    input  logic        i_dealReq,
    output logic        o_busy,
    output logic [4:0]  o_newCard,
    output logic [3:0]  o_rank,
    output logic        o_addNewCard,
    output logic        o_dealErr,
    output logic [7:0]  o_cardsRemaining,
    output logic        o_deckEmpty
);
    localparam logic [4:0] RANK_FULL = 5'(4 * NUM_DECKS);
    localparam logic [7:0] SHOE_FULL = 8'(52 * NUM_DECKS);

    typedef enum logic [2:0] {IDLE, PICK, PROBE, PRESENT, STROBE} state_t;

    state_t      state_q;
    logic [4:0]  count_q [13];
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  cand_q, rank_q;
    logic [4:0]  card_q;
    logic [7:0]  rem_q;
    logic        add_q, err_q;

    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        if (i_shuffle)
            lfsr_d = (i_seed == 16'h0) ? DEFAULT_SEED : i_seed;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int r = 0; r < 13; r++) count_q[r] <= RANK_FULL;
            lfsr_q  <= DEFAULT_SEED;
            state_q <= IDLE;
            cand_q  <= 4'd0;
            rank_q  <= 4'd0;
            card_q  <= 5'd0;
            rem_q   <= SHOE_FULL;
            add_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            lfsr_q <= lfsr_d;
            add_q  <= 1'b0;
            err_q  <= 1'b0;
            // A shuffle aborts any deal in flight before it can decrement or strobe.
            if (i_shuffle) begin
                for (int r = 0; r < 13; r++) count_q[r] <= RANK_FULL;
                rem_q   <= SHOE_FULL;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (i_dealReq && rem_q == 8'd0) err_q <= 1'b1;
                        else if (i_dealReq) state_q <= PICK;
                    end
                    PICK: begin
                        cand_q  <= (lfsr_q[3:0] >= 4'd13) ? lfsr_q[3:0] - 4'd13 : lfsr_q[3:0];
                        state_q <= PROBE;
                    end
                    PROBE: begin
                        if (count_q[cand_q] == 5'd0) begin
                            cand_q <= (cand_q == 4'd12) ? 4'd0 : cand_q + 4'd1;
                        end else begin
                            count_q[cand_q] <= count_q[cand_q] - 5'd1;
                            rem_q   <= rem_q - 8'd1;
                            rank_q  <= cand_q;
                            card_q  <= (cand_q >= 4'd10) ? 5'd10 : {1'b0, cand_q} + 5'd1;
                            state_q <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        add_q   <= 1'b1;
                        state_q <= STROBE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_busy           = (state_q != IDLE);
    assign o_newCard        = card_q;
    assign o_rank           = rank_q;
    assign o_addNewCard     = add_q;
    assign o_dealErr        = err_q;
    assign o_cardsRemaining = rem_q;
    assign o_deckEmpty      = (rem_q == 8'd0);
endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: scoreboard bench for card_dealer with an independent shoe/LFSR model.
module tb_card_dealer;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_shuffle = 1'b0;
    logic [15:0] i_seed = 16'h0;
    logic        i_dealReq = 1'b0;
    logic        o_busy, o_addNewCard, o_dealErr, o_deckEmpty;
    logic [4:0]  o_newCard;
    logic [3:0]  o_rank;
    logic [7:0]  o_cardsRemaining;

    card_dealer dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_shuffle(i_shuffle), .i_seed(i_seed),
        .i_dealReq(i_dealReq), .o_busy(o_busy), .o_newCard(o_newCard), .o_rank(o_rank),
        .o_addNewCard(o_addNewCard), .o_dealErr(o_dealErr),
        .o_cardsRemaining(o_cardsRemaining), .o_deckEmpty(o_deckEmpty)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {int rank; int card; int rem;} exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int   seen_q[$];
    int   hist[16];
    int   n_cmp = 0, n_err = 0, n_strobe = 0, sum = 0;
    int   m_cnt[13];
    int   m_rem;
    logic [15:0] m_lfsr;
    logic [4:0]  prev_card = 5'd0;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] step(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge i_clk or posedge i_reset)
        if (i_reset) m_lfsr <= 16'hACE1;
        else m_lfsr <= i_shuffle ? ((i_seed == 16'h0) ? 16'hACE1 : i_seed) : step(m_lfsr);

    task automatic refill();
        for (int r = 0; r < 13; r++) m_cnt[r] = 4;
        m_rem = 52;
    endtask

    task automatic predict(output exp_t e, output int probes);
        logic [15:0] l;
        int c;
        l = step(m_lfsr);
        c = int'(l[3:0]);
        if (c >= 13) c -= 13;
        probes = 0;
        while (m_cnt[c] == 0 && probes < 13) begin
            c = (c == 12) ? 0 : c + 1;
            probes++;
        end
        m_cnt[c]--;
        m_rem--;
        e.rank = c;
        e.card = (c >= 10) ? 10 : c + 1;
        e.rem  = m_rem;
    endtask

    always @(negedge i_clk) begin
        if (o_addNewCard) begin
            n_strobe++;
            chk("stable_pre", o_newCard, prev_card);
            chk("map", o_newCard, (o_rank >= 10) ? 10 : o_rank + 1);
            if (exp_q.size() == 0) chk("spurious_strobe", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                chk("rank", o_rank, mon_e.rank);
                chk("card", o_newCard, mon_e.card);
                chk("remaining", o_cardsRemaining, mon_e.rem);
            end
            sum += o_newCard;
            hist[o_rank]++;
            seen_q.push_back(int'(o_rank));
        end
        prev_card = o_newCard;
    end

    task automatic wait_idle();
        int w = 0;
        while (o_busy && w < 50) begin @(negedge i_clk); w++; end
        if (w >= 50) chk("idle_timeout", 1, 0);
    endtask

    task automatic deal();
        exp_t e;
        int   probes, lat;
        wait_idle();
        predict(e, probes);
        exp_q.push_back(e);
        i_dealReq = 1'b1;
        @(negedge i_clk);
        i_dealReq = 1'b0;
        lat = 1;
        while (!o_addNewCard && lat < 30) begin @(negedge i_clk); lat++; end
        chk("latency", lat, 4 + probes);
        @(negedge i_clk);
    endtask

    task automatic shuffle(input logic [15:0] s);
        wait_idle();
        i_shuffle = 1'b1;
        i_seed = s;
        @(negedge i_clk);
        i_shuffle = 1'b0;
        refill();
        sum = 0;
        for (int r = 0; r < 16; r++) hist[r] = 0;
    endtask

    initial begin
        int   errs, adds, busy_seen, probes, seq_a[$];
        exp_t e;
        refill();
        for (int r = 0; r < 16; r++) hist[r] = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        chk("rst_remaining", o_cardsRemaining, 52);
        chk("rst_empty", o_deckEmpty, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_add", o_addNewCard, 0);
        chk("rst_card", o_newCard, 0);
        chk("rst_rank", o_rank, 0);
        chk("rst_err", o_dealErr, 0);

        shuffle(16'h1234);
        deal();
        chk("one_strobe", n_strobe, 1);
        chk("rem_after_one", o_cardsRemaining, 51);
        for (int i = 0; i < 51; i++) deal();
        chk("sum_52", sum, 340);
        for (int r = 0; r < 13; r++) chk("rank_hist", hist[r], 4);
        chk("deck_empty", o_deckEmpty, 1);
        chk("rem_zero", o_cardsRemaining, 0);

        errs = 0; adds = 0; busy_seen = 0;
        i_dealReq = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge i_clk);
            i_dealReq = 1'b0;
            errs += int'(o_dealErr);
            adds += int'(o_addNewCard);
            busy_seen |= int'(o_busy);
        end
        chk("err_pulses", errs, 1);
        chk("err_no_strobe", adds, 0);
        chk("err_busy", busy_seen, 0);
        chk("strobes_total", n_strobe, 52);

        shuffle(16'h5A5A);
        deal();
        chk("rem_before_abort", o_cardsRemaining, 51);
        i_dealReq = 1'b1;
        @(negedge i_clk);
        i_dealReq = 1'b0;
        @(negedge i_clk);
        chk("probe_busy", o_busy, 1);
        i_shuffle = 1'b1;
        i_seed = 16'h0777;
        @(negedge i_clk);
        i_shuffle = 1'b0;
        refill();
        chk("abort_remaining", o_cardsRemaining, 52);
        chk("abort_busy", o_busy, 0);
        repeat (8) @(negedge i_clk);
        chk("abort_strobes", n_strobe, 53);

        shuffle(16'h0000);
        seen_q.delete();
        for (int i = 0; i < 10; i++) deal();
        seq_a = seen_q;
        shuffle(16'hACE1);
        seen_q.delete();
        for (int i = 0; i < 10; i++) deal();
        chk("seq_len", seen_q.size(), 10);
        for (int i = 0; i < 10 && i < seq_a.size() && i < seen_q.size(); i++)
            chk("seed0_seq", seen_q[i], seq_a[i]);

        wait_idle();
        predict(e, probes);
        i_dealReq = 1'b1;
        @(negedge i_clk);
        i_dealReq = 1'b0;
        repeat (2 + probes) @(negedge i_clk);
        chk("present_busy", o_busy, 1);
        chk("present_rem", o_cardsRemaining, m_rem);
        chk("present_rank", o_rank, e.rank);
        i_reset = 1'b1;
        #1;
        chk("arst_remaining", o_cardsRemaining, 52);
        chk("arst_busy", o_busy, 0);
        chk("arst_add", o_addNewCard, 0);
        chk("arst_card", o_newCard, 0);
        chk("arst_rank", o_rank, 0);
        chk("arst_empty", o_deckEmpty, 0);
        refill();
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (6) @(negedge i_clk);
        chk("arst_no_strobe", n_strobe, 73);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Card source for the game datapath. Holds a per-rank count of the cards left in the shoe.
- Picks cards pseudo-randomly with a free-running LFSR and presents each dealt card to a hand controller.
- The hand controller captures cards on the rising edge of its add strobe. This block therefore guarantees the card value is stable one full cycle before that strobe rises, and stays stable while it is high.

Parameters:
- NUM_DECKS, 1, decks in the shoe (legal range 1..4); each rank starts at 4*NUM_DECKS.
- DEFAULT_SEED, 16'hACE1, LFSR value used after reset, and in place of any zero seed.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_shuffle  input  1  refill the shoe and load i_seed; sampled every cycle.
- i_seed  input  16  LFSR seed, captured when i_shuffle=1.
- i_dealReq  input  1  request one card; sampled only in IDLE.
- o_busy  output  1  high in every state except IDLE.
- o_newCard  output  5  blackjack value of the dealt card (`card format).
- o_rank  output  4  rank of the dealt card: 0=A, 1..9 = 2..10, 10=J, 11=Q, 12=K.
- o_addNewCard  output  1  one-cycle strobe that feeds the hand controller's i_addNewCard.
- o_dealErr  output  1  one-cycle pulse when a deal is requested from an empty shoe.
- o_cardsRemaining  output  8  cards left, 0..52*NUM_DECKS.
- o_deckEmpty  output  1  high when o_cardsRemaining==0.

Behaviour:
- Reset (async, active-high):
  - every rank count = 4*NUM_DECKS; lfsr = DEFAULT_SEED; state = IDLE.
  - o_newCard=0, o_rank=0, o_addNewCard=0, o_dealErr=0, o_busy=0.
  - o_cardsRemaining = 52*NUM_DECKS; o_deckEmpty=0.
- LFSR:
  - 16-bit Galois, taps mask 16'hB400; shifts every clock in every state.
  - On i_shuffle it loads i_seed instead of shifting; a seed of 0 loads DEFAULT_SEED.
- Shuffle:
  - Takes one cycle: all counts refilled, o_cardsRemaining reloaded, state forced to IDLE.
  - Has priority over every other event, including a deal in progress; an aborted deal issues no strobe and decrements nothing.
  - o_newCard and o_rank hold their last values.
- FSM states: IDLE, PICK, PROBE, PRESENT, STROBE.
  - IDLE:
    - i_dealReq=1 and shoe empty -> o_dealErr=1 for one cycle; stay in IDLE.
    - i_dealReq=1 and shoe not empty -> PICK.
  - PICK: candidate rank = lfsr[3:0], minus 13 if it is 13 or more (the bias is accepted) -> PROBE.
  - PROBE:
    - count[candidate]==0 -> candidate = (candidate==12) ? 0 : candidate+1; stay in PROBE.
    - count[candidate]!=0 -> decrement count[candidate] and o_cardsRemaining; register o_rank and o_newCard -> PRESENT.
    - Terminates within 13 PROBE cycles, because the shoe is known non-empty.
  - PRESENT: outputs stable, o_addNewCard=0 -> STROBE.
  - STROBE: o_addNewCard=1 for exactly one cycle -> IDLE.
- Value mapping: rank 0 -> 1 (ace counts 1; soft-ace handling is downstream); rank r in 1..9 -> r+1; ranks 10..12 -> 10.
- Latency: with no probing, request sampled at edge N -> o_addNewCard high in cycle N+4. Each extra probe step adds one cycle.
- Request handling:
  - i_dealReq outside IDLE is ignored; requests do not queue.
  - A held i_dealReq deals again once the FSM returns to IDLE.
- Reset mid-deal: no strobe; all state returns to reset values.
- Counters never underflow; a count of 0 is never decremented.

Test Plan:
- Reset, then read outputs -> o_cardsRemaining=52, o_deckEmpty=0, o_busy=0, o_addNewCard=0, o_newCard=0.
- Seed 16'h1234, pulse i_dealReq once -> exactly one o_addNewCard pulse; o_newCard is stable for the cycle before and during the strobe; o_newCard matches the o_rank mapping; o_cardsRemaining=51.
- 52 back-to-back deals -> each rank dealt exactly 4 times; sum of o_newCard = 340; o_deckEmpty=1. A 53rd request -> o_dealErr pulses once, no strobe, o_busy stays 0.
- Deal down to 4 remaining cards, all the same rank after forced probing -> each deal still strobes within 16 cycles and o_rank equals that rank.
- Assert i_shuffle during PROBE -> no strobe, o_cardsRemaining=52 the next cycle, state IDLE. Seeds 0 and 16'hACE1 give identical rank sequences over 10 deals.
- Assert i_reset during PRESENT -> o_addNewCard never rises; all outputs at reset values immediately, without waiting for a clock edge.
